transmit: RTL and testbench

- UART transmitter, 8N1, LSB first; the companion of the serial receiver on the same link.
- Accepts bytes on a valid/ready slave stream and serialises them onto `tx` at BAUD.
- Has a one-byte holding register, so back-to-back bytes go out with no idle gap between frames.
- Sits between the host-side stream logic and the FPGA serial pin.

---
 rtl/transmit.sv | 89 ++++++++
 tb/tb_transmit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/transmit.sv
// transmit: UART transmitter (8N1, LSB first) with a one-byte holding register for gapless frames.
// Define TRANSMIT_PARITY_EN to insert an even parity bit (8E1).
module transmit #(
  parameter int BAUD = 9600,
  parameter int FREQ = 12_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       tx,
  output logic       busy
);
  localparam int DIV = (FREQ + BAUD / 2) / BAUD;
  localparam int CW = $clog2(DIV);
`ifdef TRANSMIT_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, hold;
  logic hold_full, hold_full_n, tick, load, take, tx_n;
`ifdef TRANSMIT_PARITY_EN
  logic par;
`endif
  assign tick = cnt == '0;
  assign take = s_valid && s_ready;
  assign busy = state != IDLE || hold_full;
  always_comb begin
    state_n = state;
    load = 1'b0;
    case (state)
      IDLE: load = hold_full;
      START: state_n = tick ? DATA : START;
`ifdef TRANSMIT_PARITY_EN
      DATA: state_n = tick && idx == 3'd7 ? PARITY : DATA;
      PARITY: state_n = tick ? STOP : PARITY;
`else
      DATA: state_n = tick && idx == 3'd7 ? STOP : DATA;
`endif
      STOP: begin
        load = tick && hold_full;
        state_n = tick ? IDLE : STOP;
      end
      default: state_n = IDLE;
    endcase
    if (load) state_n = START;
    hold_full_n = take || (hold_full && !load);
    shift_n = load ? hold : state == DATA && tick ? shift >> 1 : shift;
    idx_n = load ? 3'd0 : state == DATA && tick ? idx + 3'd1 : idx;
    cnt_n = state_n == IDLE ? '0 : tick ? CW'(DIV - 1) : cnt - CW'(1);
    tx_n = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`ifdef TRANSMIT_PARITY_EN
    if (state == PARITY) tx_n = par;
`endif
  end
  // tx is driven from the current state, so the line lags the FSM by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= 3'd0;
      shift <= 8'd0;
      hold <= 8'd0;
      hold_full <= 1'b0;
      s_ready <= 1'b1;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      hold_full <= hold_full_n;
      s_ready <= !hold_full_n;
      tx <= tx_n;
      if (take) hold <= s_data;
    end
  end
`ifdef TRANSMIT_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par <= 1'b0;
    else if (load) par <= ^hold;
  end
`endif
endmodule

// File: tb/tb_transmit.sv
// tb_transmit: directed bench for transmit; every cycle is checked against a frame-timeline model.
module tb_transmit;
  localparam int D = 10;
`ifdef TRANSMIT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, s_ready, tx, busy;
  logic [7:0] s_data = 8'd0;
  int asserts = 0, fails = 0, cyc = 0;
  int fk[$], fs[$];
  logic [7:0] fd[$];
  logic [7:0] pat [4] = '{8'h00, 8'hFF, 8'h55, 8'hAA};

  transmit #(.BAUD(1_000_000), .FREQ(10_000_000)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s at cycle %0d: got %0h, expected %0h", n, cyc, got, exp);
    end
  endtask

  // Model: a frame accepted at edge k starts on the line at max(k+2, previous start + frame length).
  function automatic logic exp_tx(input int c);
    int b;
    logic [7:0] d;
    for (int i = 0; i < fs.size(); i++) begin
      if (c >= fs[i] && c < fs[i] + NB * D) begin
        b = (c - fs[i]) / D;
        d = fd[i];
        return b == 0 ? 1'b0 : b <= 8 ? d[b - 1] : (NB == 11 && b == 9) ? ^d : 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int c);
    for (int i = 0; i < fs.size(); i++)
      if (c >= fk[i] && c <= fs[i] + NB * D - 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_ready(input int c);
    for (int i = 0; i < fs.size(); i++)
      if (c >= fk[i] && c <= fs[i] - 2) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      fk.delete();
      fs.delete();
      fd.delete();
    end else if (s_valid && exp_ready(cyc - 1)) begin
      fk.push_back(cyc);
      fs.push_back(fs.size() > 0 && fs[$] + NB * D > cyc + 2 ? fs[$] + NB * D : cyc + 2);
      fd.push_back(s_data);
    end
  end

  always @(negedge clk) begin
    chk("tx", tx, exp_tx(cyc));
    chk("busy", busy, exp_busy(cyc));
    chk("s_ready", s_ready, exp_ready(cyc));
  end

  task automatic send(input logic [7:0] b);
    int g = 0;
    s_valid = 1'b1;
    s_data = b;
    while (s_ready !== 1'b1 && g < 5000) begin @(negedge clk); g++; end
    chk("send_ready_seen", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_low(output int c);
    int g = 0;
    while (tx !== 1'b0 && g < 1000) begin @(negedge clk); g++; end
    chk("tx_start_seen", tx, 0);
    c = cyc;
  endtask

  task automatic wait_idle(output int c);
    int g = 0;
    while (busy !== 1'b0 && g < 5000) begin @(negedge clk); g++; end
    chk("busy_drop_seen", busy, 0);
    c = cyc;
  endtask

  initial begin
    int s, b, g, n, lows;
    logic t;
    logic [9:0] bits;
    logic [10:0] fr;
    logic [7:0] v;
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_ready", s_ready, 1);
    chk("reset_busy", busy, 0);
    rst = 1'b1;
    repeat (500) @(negedge clk);
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);
    chk("idle_ready", s_ready, 1);
    b = cyc + 1;
    send(8'hA5);
    wait_low(s);
    chk("start_latency", s - b, 2);
    for (int i = 0; i < 10; i++) begin
      while (cyc < s + i * D + D / 2) @(negedge clk);
      bits[i] = tx;
    end
    chk("a5_bits", bits, NB == 11 ? 10'b0101001010 : 10'b1101001010);
    wait_idle(g);
    chk("a5_frame_len", g - s, NB * D - 1);
    for (int k = 0; k < 8; k++) begin
      v = 8'($urandom);
      send(v);
      wait_low(s);
      fr = '0;
      for (int i = 0; i < NB; i++) begin
        while (cyc < s + i * D + D / 2) @(negedge clk);
        fr[i] = tx;
      end
      chk("rx_byte", fr[8:1], v);
      chk("rx_stop", fr[NB - 1], 1);
`ifdef TRANSMIT_PARITY_EN
      chk("rx_parity", fr[9], ^v);
`endif
      wait_idle(g);
    end
    s_valid = 1'b1;
    s_data = pat[0];
    n = 0;
    s = -1;
    g = 0;
    while (n < 4 && g < 20 * NB * D) begin
      t = s_ready;
      @(negedge clk);
      g++;
      if (tx === 1'b0 && s < 0) s = cyc;
      if (t) begin
        n++;
        if (n < 4) s_data = pat[n];
        else s_valid = 1'b0;
      end
    end
    chk("stream_count", n, 4);
    wait_idle(g);
    chk("stream_len", g - s, 4 * NB * D - 1);
    send(8'h3C);
    wait_low(s);
    send(8'h81);
    while (cyc < s + 4 * D + D / 2) @(negedge clk);
    chk("mid_frame_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", s_ready, 1);
    chk("post_rst_busy", busy, 0);
    lows = 0;
    repeat (3 * NB * D) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no_residual_frame", lows, 0);
`ifdef TRANSMIT_PARITY_EN
    send(8'h07);
    wait_low(s);
    while (cyc < s + 9 * D + D / 2) @(negedge clk);
    chk("parity_07", tx, 1);
    wait_idle(g);
    chk("parity_07_len", g - s, 11 * D - 1);
    send(8'h03);
    wait_low(s);
    while (cyc < s + 9 * D + D / 2) @(negedge clk);
    chk("parity_03", tx, 0);
    wait_idle(g);
    chk("parity_03_len", g - s, 11 * D - 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
